// File: rtl/pairing_bridge_pkg.sv
// Shared constants, op codes and FSM states for the pairing core host bridge.
// Included by the bridge top and its bit buffer.
package pairing_bridge_pkg;

   localparam int DATA_W  = 1188;
   localparam int WORD_W  = 32;
   localparam int NWORDS  = (DATA_W + WORD_W - 1) / WORD_W;
   localparam int ADDR_W  = 6;
   localparam int BUF_W   = NWORDS * WORD_W;
   localparam int WORD_SH = $clog2(WORD_W);
   localparam int TAIL_W  = DATA_W - (NWORDS - 1) * WORD_W;

   localparam int BIT_CW  = 11;
   localparam int WORD_CW = 6;

   localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(DATA_W - 1);
   localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(NWORDS - 1);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [3:0] {
      IDLE,
      W_LOAD,
      W_UPD,
      W_SHIFT,
      W_COMMIT,
      R_SETUP,
      R_UPD,
      R_SHIFT,
      R_DRAIN,
      RUN
   } state_e;

   // Only the last word is partial; its bits above DATA_W read back as 0.
   function automatic logic [WORD_W-1:0] word_mask(
      input logic [WORD_CW-1:0] k
   );
      logic [WORD_W-1:0] m;
      m = '1;
      if (k == LAST_WORD) begin
         m = WORD_W'((64'd1 << TAIL_W) - 64'd1);
      end
      return m;
   endfunction

endpackage

// File: rtl/pairing_bit_buffer.sv
// Operand buffer: word-wide access from the host side,
// single-bit access from the serial side.
module pairing_bit_buffer
   import pairing_bridge_pkg::*;
(
   input  logic               clk_i,
   input  logic               word_we_i,
   input  logic [WORD_CW-1:0] word_widx_i,
   input  logic [WORD_W-1:0]  word_wdata_i,
   input  logic [WORD_CW-1:0] word_ridx_i,
   output logic [WORD_W-1:0]  word_rdata_o,
   input  logic               bit_we_i,
   input  logic [BIT_CW-1:0]  bit_widx_i,
   input  logic               bit_wdata_i,
   input  logic [BIT_CW-1:0]  bit_ridx_i,
   output logic               bit_rdata_o
);

   logic [BUF_W-1:0] mem_q;

   // Contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (word_we_i) begin
         mem_q[{word_widx_i, {WORD_SH{1'b0}}} +: WORD_W] <= word_wdata_i;
      end
      if (bit_we_i) begin
         mem_q[bit_widx_i] <= bit_wdata_i;
      end
   end

   assign word_rdata_o =
      mem_q[{word_ridx_i, {WORD_SH{1'b0}}} +: WORD_W]
      & word_mask(word_ridx_i);

   assign bit_rdata_o = mem_q[bit_ridx_i];

endmodule

// File: rtl/pairing_host_bridge.sv
// Word-parallel host to bit-serial pairing core bridge:
// WRITE loads an operand, READ fetches a result, RUN runs the core.
module pairing_host_bridge
   import pairing_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [WORD_W-1:0] rd_data,
   output logic              busy,
   output logic              run_done,
   output logic [31:0]       run_cycles,
   output logic              core_reset,
   output logic              core_sel,
   output logic [ADDR_W-1:0] core_addr,
   output logic              core_w,
   output logic              core_update,
   output logic              core_ready,
   output logic              core_i,
   input  logic              core_o,
   input  logic              core_done
);

   state_e             state_q, state_d;
   logic [BIT_CW-1:0]  bit_q, bit_d;
   logic [WORD_CW-1:0] word_q, word_d;
   logic               dly_q;
   logic               cmd_acc, wr_acc, rd_acc, done_rise;
   logic [WORD_W-1:0]  buf_word;
   logic               buf_bit;

   assign cmd_acc   = cmd_valid & cmd_ready;
   assign wr_acc    = wr_valid & wr_ready;
   assign rd_acc    = rd_valid & rd_ready;
   assign done_rise = (state_q == RUN) & core_done & ~dly_q;

   pairing_bit_buffer u_buf (
      .clk_i        (clk),
      .word_we_i    (wr_acc),
      .word_widx_i  (word_q),
      .word_wdata_i (wr_data),
      .word_ridx_i  (word_d),
      .word_rdata_o (buf_word),
      .bit_we_i     (state_q == R_SHIFT),
      .bit_widx_i   (bit_q),
      .bit_wdata_i  (core_o),
      .bit_ridx_i   (bit_d),
      .bit_rdata_o  (buf_bit)
   );

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      word_d  = word_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               bit_d  = '0;
               word_d = '0;
               unique case (cmd_op)
                  OP_WRITE: state_d = W_LOAD;
                  OP_READ:  state_d = R_SETUP;
                  OP_RUN:   state_d = RUN;
                  OP_RSVD:  state_d = IDLE;
               endcase
            end
         end
         W_LOAD: begin
            if (wr_acc) begin
               word_d = word_q + 1'b1;
               if (word_q == LAST_WORD) state_d = W_UPD;
            end
         end
         W_UPD: begin
            bit_d   = '0;
            state_d = W_SHIFT;
         end
         W_SHIFT: begin
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = W_COMMIT;
         end
         W_COMMIT: state_d = IDLE;
         R_SETUP:  state_d = R_UPD;
         R_UPD: begin
            bit_d   = '0;
            state_d = R_SHIFT;
         end
         R_SHIFT: begin
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
               word_d  = '0;
               state_d = R_DRAIN;
            end
         end
         R_DRAIN: begin
            if (rd_acc) begin
               word_d = word_q + 1'b1;
               if (word_q == LAST_WORD) state_d = IDLE;
            end
         end
         RUN: begin
            if (done_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_q       <= '0;
         word_q      <= '0;
         dly_q       <= 1'b0;
         cmd_ready   <= 1'b0;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         run_cycles  <= '0;
         core_reset  <= 1'b1;
         core_sel    <= 1'b1;
         core_addr   <= '0;
         core_w      <= 1'b0;
         core_update <= 1'b0;
         core_ready  <= 1'b0;
         core_i      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         word_q      <= word_d;
         dly_q       <= core_done;
         if (cmd_acc) core_addr <= cmd_addr;
         cmd_ready   <= (state_d == IDLE);
         wr_ready    <= (state_d == W_LOAD);
         rd_valid    <= (state_d == R_DRAIN);
         rd_data     <= (state_d == R_DRAIN) ? buf_word : '0;
         busy        <= (state_d != IDLE);
         run_done    <= done_rise;
         core_reset  <= (state_d != RUN);
         core_sel    <= (state_d != RUN);
         core_w      <= (state_d == W_COMMIT);
         core_update <= (state_d == W_UPD) || (state_d == R_UPD);
         core_ready  <= (state_d == W_SHIFT) || (state_d == R_SHIFT);
         core_i      <= (state_d == W_SHIFT) & buf_bit;
         if (state_q != RUN && state_d == RUN) begin
            run_cycles <= '0;
         end else if (state_q == RUN && !done_rise
                      && run_cycles != '1) begin
            run_cycles <= run_cycles + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pairing_host_bridge.sv
// Randomized self-checking bench for pairing_host_bridge with a
// behavioural operand/core model.
module tb_pairing_host_bridge;

   localparam int DW = 1188;
   localparam int WW = 32;
   localparam int NW = (DW + WW - 1) / WW;

   localparam logic [1:0] OPW = 2'd0;
   localparam logic [1:0] OPR = 2'd1;
   localparam logic [1:0] OPN = 2'd2;
   localparam logic [1:0] OPX = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [5:0]  cmd_addr = 6'd0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_data = 32'd0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic        busy;
   logic        run_done;
   logic [31:0] run_cycles;
   logic        core_reset;
   logic        core_sel;
   logic [5:0]  core_addr;
   logic        core_w;
   logic        core_update;
   logic        core_ready;
   logic        core_i;
   logic        core_o = 1'b0;
   logic        core_done = 1'b0;

   int total = 0;
   int bad = 0;
   int wpulses = 0;

   logic [31:0] wbuf [NW];
   logic        rbits [DW];

   pairing_host_bridge dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .busy        (busy),
      .run_done    (run_done),
      .run_cycles  (run_cycles),
      .core_reset  (core_reset),
      .core_sel    (core_sel),
      .core_addr   (core_addr),
      .core_w      (core_w),
      .core_update (core_update),
      .core_ready  (core_ready),
      .core_i      (core_i),
      .core_o      (core_o),
      .core_done   (core_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_w === 1'b1) wpulses++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic wbit(input int j);
      return wbuf[j / WW][j % WW];
   endfunction

   task automatic issue(input logic [1:0] op, input logic [5:0] a);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL cmd_wait: cmd_ready=%b need 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic load_words();
      int   k = 0;
      int   guard = 0;
      logic acc;
      while (k < NW && guard < 1000) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = wbuf[k];
         acc      = wr_valid && wr_ready;
         tick();
         if (acc) k++;
         guard++;
      end
      wr_valid = 1'b0;
      total++;
      if (k != NW) begin
         bad++;
         $display("FAIL wr_load: words=%0d need %0d", k, NW);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({core_reset, core_sel, core_w, core_update,
           core_ready, core_i, core_addr} !== {2'b11, 4'b0, 6'd0}) begin
         bad++;
         $display("FAIL reset_core: got %b%b%b%b%b%b %h",
                  core_reset, core_sel, core_w, core_update,
                  core_ready, core_i, core_addr);
      end
      total++;
      if ({cmd_ready, wr_ready, rd_valid, busy, run_done} !== 5'b0
          || rd_data !== 32'd0 || run_cycles !== 32'd0) begin
         bad++;
         $display("FAIL reset_host: rdy=%b wr=%b rv=%b busy=%b rd=%h rc=%0d",
                  cmd_ready, wr_ready, rd_valid, busy, rd_data, run_cycles);
      end
      reset = 1'b0;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: cmd_ready=%b need 0", cmd_ready);
      end
      tick();
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL first_ready: cmd_ready=%b need 1", cmd_ready);
      end
   endtask

   task automatic test_write(input logic [5:0] a, input bit rnd);
      int ub = 0, rb = 0, ib = 0, wb = 0, ab = 0;
      for (int k = 0; k < NW; k++) begin
         wbuf[k] = rnd ? $urandom : 32'hA5A5_0000 + k;
      end
      issue(OPW, a);
      total++;
      if (wr_ready !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL wr_enter: wr_ready=%b busy=%b need 1 1",
                  wr_ready, busy);
      end
      load_words();
      for (int c = 0; c < DW + 2; c++) begin
         if (core_update !== (c == 0)) ub++;
         if (core_ready !== (c >= 1 && c <= DW)) rb++;
         if (c >= 1 && c <= DW && core_i !== wbit(c - 1)) ib++;
         if (core_w !== (c == DW + 1)) wb++;
         if (core_addr !== a || core_reset !== 1'b1
             || core_sel !== 1'b1) ab++;
         wr_valid = $urandom_range(0, 1);
         tick();
      end
      wr_valid = 1'b0;
      total++;
      if (ub != 0) begin
         bad++;
         $display("FAIL wr_update: bad cycles=%0d need 0", ub);
      end
      total++;
      if (rb != 0) begin
         bad++;
         $display("FAIL wr_ready_win: bad cycles=%0d need 0", rb);
      end
      total++;
      if (ib != 0) begin
         bad++;
         $display("FAIL wr_stream: bad bits=%0d need 0", ib);
      end
      total++;
      if (wb != 0) begin
         bad++;
         $display("FAIL wr_commit: bad cycles=%0d need 0", wb);
      end
      total++;
      if (ab != 0) begin
         bad++;
         $display("FAIL wr_addr_ctl: bad cycles=%0d need 0", ab);
      end
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL wr_end: cmd_ready=%b busy=%b need 1 0",
                  cmd_ready, busy);
      end
   endtask

   task automatic test_read(input logic [5:0] a, input bit rnd);
      logic [31:0] exp [NW];
      int ub = 0, rb = 0, ab = 0, db = 0;
      int k = 0, guard = 0;
      logic acc;
      for (int j = 0; j < DW; j++) begin
         rbits[j] = rnd ? 1'($urandom_range(0, 1)) : 1'((j >> 2) & 1);
      end
      for (int i = 0; i < NW; i++) exp[i] = 32'd0;
      for (int j = 0; j < DW; j++) exp[j / WW][j % WW] = rbits[j];
      issue(OPR, a);
      for (int c = 0; c < DW + 2; c++) begin
         if (core_update !== (c == 1)) ub++;
         if (core_ready !== (c >= 2 && c <= DW + 1)) rb++;
         if (core_addr !== a || core_reset !== 1'b1
             || core_sel !== 1'b1 || rd_valid !== 1'b0) ab++;
         core_o   = (c >= 2 && c <= DW + 1) ? rbits[c - 2] : 1'b0;
         rd_ready = $urandom_range(0, 1);
         tick();
      end
      core_o = 1'b0;
      while (k < NW && guard < 1000) begin
         if (rd_valid !== 1'b1 || rd_data !== exp[k]) begin
            db++;
            if (db < 4) begin
               $display("FAIL rd_word%0d: valid=%b data=%h need 1 %h",
                        k, rd_valid, rd_data, exp[k]);
            end
         end
         rd_ready = ($urandom_range(0, 2) != 0);
         acc      = rd_ready && rd_valid;
         tick();
         if (acc) k++;
         guard++;
      end
      rd_ready = 1'b0;
      total++;
      if (ub != 0) begin
         bad++;
         $display("FAIL rd_update: bad cycles=%0d need 0", ub);
      end
      total++;
      if (rb != 0) begin
         bad++;
         $display("FAIL rd_ready_win: bad cycles=%0d need 0", rb);
      end
      total++;
      if (ab != 0) begin
         bad++;
         $display("FAIL rd_addr_ctl: bad cycles=%0d need 0", ab);
      end
      total++;
      if (db != 0) begin
         bad++;
         $display("FAIL rd_data: bad samples=%0d need 0", db);
      end
      total++;
      if (k != NW || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL rd_end: words=%0d rv=%b rdy=%b need %0d 0 1",
                  k, rd_valid, cmd_ready, NW);
      end
   endtask

   task automatic test_run(input int d);
      int rb = 0;
      core_done = 1'b0;
      issue(OPN, 6'($urandom_range(0, 63)));
      for (int c = 0; c < d; c++) begin
         if (core_reset !== 1'b0 || core_sel !== 1'b0 || core_w !== 1'b0
             || run_done !== 1'b0 || busy !== 1'b1) rb++;
         tick();
      end
      core_done = 1'b1;
      tick();
      total++;
      if (run_done !== 1'b1) begin
         bad++;
         $display("FAIL run_pulse: run_done=%b need 1", run_done);
      end
      total++;
      if (run_cycles !== 32'(d)) begin
         bad++;
         $display("FAIL run_cycles: got %0d need %0d", run_cycles, d);
      end
      total++;
      if (core_reset !== 1'b1 || core_sel !== 1'b1) begin
         bad++;
         $display("FAIL run_release: reset=%b sel=%b need 1 1",
                  core_reset, core_sel);
      end
      tick();
      total++;
      if (run_done !== 1'b0 || cmd_ready !== 1'b1
          || run_cycles !== 32'(d)) begin
         bad++;
         $display("FAIL run_after: done=%b rdy=%b rc=%0d need 0 1 %0d",
                  run_done, cmd_ready, run_cycles, d);
      end
      core_done = 1'b0;
      total++;
      if (rb != 0) begin
         bad++;
         $display("FAIL run_active: bad cycles=%0d need 0", rb);
      end
   endtask

   task automatic test_run_done_high();
      int rb = 0;
      core_done = 1'b1;
      issue(OPN, 6'd0);
      for (int c = 0; c < 25; c++) begin
         if (c == 20) core_done = 1'b0;
         if (run_done !== 1'b0 || core_reset !== 1'b0) rb++;
         tick();
      end
      core_done = 1'b1;
      tick();
      total++;
      if (rb != 0) begin
         bad++;
         $display("FAIL hi_early: bad cycles=%0d need 0", rb);
      end
      total++;
      if (run_done !== 1'b1 || run_cycles !== 32'd25) begin
         bad++;
         $display("FAIL hi_done: done=%b rc=%0d need 1 25",
                  run_done, run_cycles);
      end
      tick();
      core_done = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int w0;
      for (int k = 0; k < NW; k++) wbuf[k] = $urandom;
      issue(OPW, 6'd5);
      load_words();
      w0 = wpulses;
      for (int c = 0; c < 601; c++) tick();
      total++;
      if (core_ready !== 1'b1 || core_i !== wbit(600)) begin
         bad++;
         $display("FAIL mid_shift: ready=%b i=%b need 1 %b",
                  core_ready, core_i, wbit(600));
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if ({core_reset, core_sel, core_w, core_update,
           core_ready, core_i, core_addr} !== {2'b11, 4'b0, 6'd0}) begin
         bad++;
         $display("FAIL mid_reset_core: got %b%b%b%b%b%b %h",
                  core_reset, core_sel, core_w, core_update,
                  core_ready, core_i, core_addr);
      end
      total++;
      if ({cmd_ready, wr_ready, rd_valid, busy, run_done} !== 5'b0) begin
         bad++;
         $display("FAIL mid_reset_host: got %b%b%b%b%b need 00000",
                  cmd_ready, wr_ready, rd_valid, busy, run_done);
      end
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      total++;
      if (wpulses != w0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_no_commit: wpulses=%0d rdy=%b need %0d 1",
                  wpulses, cmd_ready, w0);
      end
   endtask

   task automatic test_rsvd();
      issue(OPX, 6'd0);
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || core_reset !== 1'b1
          || core_sel !== 1'b1
          || {core_w, core_update, core_ready} !== 3'b000) begin
         bad++;
         $display("FAIL rsvd_idle: busy=%b rdy=%b rst=%b sel=%b",
                  busy, cmd_ready, core_reset, core_sel);
      end
      issue(OPN, 6'd0);
      total++;
      if (core_reset !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rsvd_next: core_reset=%b busy=%b need 0 1",
                  core_reset, busy);
      end
      core_done = 1'b1;
      tick();
      total++;
      if (run_done !== 1'b1 || run_cycles !== 32'd0) begin
         bad++;
         $display("FAIL rsvd_run: done=%b rc=%0d need 1 0",
                  run_done, run_cycles);
      end
      tick();
      core_done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write(6'd3, 1'b0);
      test_write(6'($urandom_range(0, 63)), 1'b1);
      test_read(6'd9, 1'b0);
      test_read(6'($urandom_range(0, 63)), 1'b1);
      test_run(50);
      test_run($urandom_range(1, 200));
      test_run_done_high();
      test_reset_mid_write();
      test_write(6'd7, 1'b1);
      test_rsvd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pairing_host_bridge.md
Name: pairing_host_bridge

Overview:
Upstream driver for the pairing core's bit-serial port (sel/addr/w/update/ready/i/o/done). It converts word-parallel host commands into the core's serial protocol:
- WRITE: load an operand into a core address.
- READ: fetch a result from a core address.
- RUN: release the core's reset and wait for done.

A full 1188-bit operand is buffered internally, so the serial phases never stall.

Parameters:
DATA_W, 1188, bits per GF(3^M) operand on the serial port (WIDTH_D0+1)
WORD_W, 32, host data word width
NWORDS, 38, ceil(DATA_W/WORD_W); derived, not overridable
ADDR_W, 6, core address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  bridge can accept a command
cmd_op  in  2  0=WRITE, 1=READ, 2=RUN, 3=reserved
cmd_addr  in  ADDR_W  core address (ignored for RUN)
wr_valid  in  1  write-word valid
wr_ready  out  1  write-word accepted
wr_data  in  WORD_W  operand word, least-significant word first
rd_valid  out  1  read-word valid
rd_ready  in  1  host accepts read word
rd_data  out  WORD_W  result word, least-significant word first
busy  out  1  state != IDLE
run_done  out  1  one-cycle pulse when RUN completes
run_cycles  out  32  cycles spent in the last RUN; holds its value until the next RUN
core_reset  out  1  to core reset; 1 = core FSM silent
core_sel  out  1  to core sel
core_addr  out  ADDR_W  to core addr
core_w  out  1  to core w
core_update  out  1  to core update
core_ready  out  1  to core ready
core_i  out  1  to core i
core_o  in  1  from core o
core_done  in  1  from core done

Behaviour:
- Reset values:
  - core_reset=1, core_sel=1; all other core_* outputs = 0.
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0.
  - run_done=0, run_cycles=0, busy=0; state=IDLE.
  - cmd_ready rises on the first clock after reset deasserts.
- core_reset=1 in every state except RUN.
- core_sel=1 in every state except RUN.
- core_addr is latched from cmd_addr on command accept and held until the next accept.
- IDLE:
  - cmd_ready=1; a command is accepted on cmd_valid&cmd_ready.
  - WRITE -> W_LOAD; READ -> R_SETUP; RUN -> RUN.
  - Op 3 is accepted and dropped (stay IDLE).
- W_LOAD:
  - wr_ready=1; word k is stored at buffer bits [WORD_W*k +: WORD_W], k=0..NWORDS-1.
  - In word 37, bits above DATA_W-1 (wr_data[31:4]) are discarded.
  - After 38 accepted words -> W_UPD.
- W_UPD: core_update=1 for exactly 1 cycle -> W_SHIFT.
- W_SHIFT:
  - core_ready=1 for exactly DATA_W consecutive cycles.
  - During cycle j, core_i = buffer bit j (LSB first) -> W_COMMIT.
- W_COMMIT: core_w=1 for 1 cycle -> IDLE.
- R_SETUP: 1 idle cycle with the address driven -> R_UPD.
- R_UPD: core_update=1 for 1 cycle -> R_SHIFT.
- R_SHIFT:
  - core_ready=1 for DATA_W consecutive cycles.
  - core_o is sampled at the end of cycle j into buffer bit j -> R_DRAIN.
- R_DRAIN:
  - rd_valid=1, rd_data = word k; advance on rd_valid&rd_ready.
  - rd_data/rd_valid stay stable while rd_ready=0.
  - Word 37 carries bits[3:0] = data bits 1187..1184, upper bits 0.
  - After word 37 is accepted -> IDLE.
- RUN:
  - core_reset=0, core_sel=0, core_w=0; run_cycles cleared on entry, +1 per cycle.
  - The core_done edge is detected with a 1-cycle-delayed register initialised to the core_done value on RUN entry.
  - On a detected rising edge: run_done=1 for 1 cycle, run_cycles frozen -> IDLE (core_reset re-asserted).
  - run_cycles saturates at 2^32-1.
- Latencies:
  - WRITE: 38 word cycles (minimum) + 1 + DATA_W + 1.
  - READ: 1 + 1 + DATA_W + 38 word cycles (minimum).
- Asynchronous reset mid-operation: the state machine returns to IDLE immediately; all outputs take their reset values; the buffer is not cleared; a partial write is never committed (core_w is never pulsed).
- wr_valid outside W_LOAD is ignored. rd_ready outside R_DRAIN is ignored.

Decomposition:
- Package pairing_bridge_pkg:
  - DATA_W, WORD_W, NWORDS, ADDR_W.
  - Op encodings OP_WRITE/OP_READ/OP_RUN/OP_RSVD.
  - State enum: IDLE, W_LOAD, W_UPD, W_SHIFT, W_COMMIT, R_SETUP, R_UPD, R_SHIFT, R_DRAIN, RUN.
  - Counter widths: bit counter 11 bits, word counter 6 bits.
- Sub-module pairing_bit_buffer: DATA_W-bit register supporting:
  - word write at index k;
  - word read at index k;
  - serial bit read/write at index j.
- The FSM and counters stay in pairing_host_bridge.

Test Plan:
- WRITE addr 3, words 0..37 = 32'hA5A5_0000+k -> core_update high 1 cycle; core_ready high exactly 1188 cycles; core_i stream equals the packed bits LSB-first; then core_w=1 for 1 cycle; core_addr=3 throughout; core_reset=1.
- READ addr 9 with a core model driving the bit pattern 0x…F0F0 (bit j = (j>>2)&1) -> 1 setup cycle, then 1 update cycle, then 1188 ready cycles; 38 rd words each 32'hF0F0F0F0 except word 37 = 32'h00000000; random rd_ready stalls keep rd_data stable.
- RUN with a core model raising core_done 50 cycles after core_reset falls -> run_done single pulse; run_cycles=50; core_reset back to 1; core_sel back to 1; cmd_ready=1 next cycle.
- RUN entered while core_done is already 1 -> no completion until core_done falls then rises again.
- Assert reset at W_SHIFT bit 600 -> all core_* outputs return to reset values the same cycle; core_w never pulses; the next WRITE completes normally.
- Op 3 accepted in IDLE -> no core_* activity; busy stays 0; the next command is accepted on the following cycle.
